// File: rtl/x_phaser_out_ctl.sv
// -----------------------------------------------------------------------------
// x_phaser_out_ctl
// Control plane of the write-side (output) phaser. All logic runs on SYSCLK.
//   - fine (0..63) and coarse (0..7) saturating delay tap counters
//   - counter load (COUNTERLOADEN) and readback capture (COUNTERREADEN)
//   - OCLKDIV divided-clock generator with divider reset and edge advance
//   - OSERDESRST sequencer, released on the second cnt==0 after divider start
//
// Ports
//   SYSCLK          in   sole clock, posedge
//   RSTB            in   asynchronous active-low reset
//   FINEENABLE/INC  in   fine step request / direction (1 = up)
//   COARSEENABLE/INC in  coarse step request / direction (1 = up)
//   COUNTERLOADEN   in   load taps from COUNTERLOADVAL {coarse[2:0], fine[5:0]}
//   COUNTERREADEN   in   capture pre-edge {coarse, fine} into COUNTERREADVAL
//   DIVIDERST       in   level divider hold; parks cnt at CLKOUT_DIV-1
//   EDGEADV         in   one-cycle pulse, advances OCLKDIV phase by one cycle
//   COUNTERREADVAL  out  captured taps
//   FINEOVERFLOW    out  fine step attempted past a bound
//   COARSEOVERFLOW  out  coarse step attempted past a bound
//   OCLKDIV         out  registered divided clock
//   OSERDESRST      out  serializer reset (tied 0 when EN_OSERDES_RST="FALSE")
// -----------------------------------------------------------------------------
module x_phaser_out_ctl #(
    parameter int CLKOUT_DIV     = 4,
    parameter int FINE_DELAY     = 0,
    parameter int COARSE_DELAY   = 0,
    parameter     EN_OSERDES_RST = "FALSE"
) (
    input  logic       SYSCLK,
    input  logic       RSTB,
    input  logic       FINEENABLE,
    input  logic       FINEINC,
    input  logic       COARSEENABLE,
    input  logic       COARSEINC,
    input  logic       COUNTERLOADEN,
    input  logic [8:0] COUNTERLOADVAL,
    input  logic       COUNTERREADEN,
    input  logic       DIVIDERST,
    input  logic       EDGEADV,
    output logic [8:0] COUNTERREADVAL,
    output logic       FINEOVERFLOW,
    output logic       COARSEOVERFLOW,
    output logic       OCLKDIV,
    output logic       OSERDESRST
);

    // Elaboration-time attribute checks; an illegal value stops the build.
    if (CLKOUT_DIV < 2 || CLKOUT_DIV > 16) begin : g_bad_div
        $fatal(1, "Attribute Syntax Error : %m CLKOUT_DIV=%0d, legal 2..16", CLKOUT_DIV);
    end
    if (FINE_DELAY < 0 || FINE_DELAY > 63) begin : g_bad_fine
        $fatal(1, "Attribute Syntax Error : %m FINE_DELAY=%0d, legal 0..63", FINE_DELAY);
    end
    if (COARSE_DELAY < 0 || COARSE_DELAY > 7) begin : g_bad_coarse
        $fatal(1, "Attribute Syntax Error : %m COARSE_DELAY=%0d, legal 0..7", COARSE_DELAY);
    end
    if (EN_OSERDES_RST != "TRUE" && EN_OSERDES_RST != "FALSE") begin : g_bad_en
        $fatal(1, "Attribute Syntax Error : %m EN_OSERDES_RST, legal TRUE or FALSE");
    end

    localparam logic [4:0] DIV_W   = 5'(CLKOUT_DIV);
    localparam logic [4:0] HALF_W  = 5'(CLKOUT_DIV / 2);
    localparam logic [3:0] PARK    = 4'(CLKOUT_DIV - 1);
    localparam logic [5:0] FINE_RV = 6'(FINE_DELAY);
    localparam logic [2:0] CRS_RV  = 3'(COARSE_DELAY);

    // ------------------------------------------------------------------ taps
    logic [5:0] fine_q,   fine_d;
    logic [2:0] coarse_q, coarse_d;
    logic       fovf_q,   fovf_d;
    logic       covf_q,   covf_d;
    logic [8:0] rdval_q;

    always_comb begin
        fine_d   = fine_q;
        coarse_d = coarse_q;
        fovf_d   = fovf_q;
        covf_d   = covf_q;
        if (COUNTERLOADEN) begin
            fine_d   = COUNTERLOADVAL[5:0];
            coarse_d = COUNTERLOADVAL[8:6];
            fovf_d   = 1'b0;
            covf_d   = 1'b0;
        end else begin
            // A step into a bound is swallowed and flagged; a real move clears the flag.
            if (FINEENABLE) begin
                if (FINEINC ? (fine_q == 6'd63) : (fine_q == 6'd0)) begin
                    fovf_d = 1'b1;
                end else begin
                    fine_d = FINEINC ? fine_q + 6'd1 : fine_q - 6'd1;
                    fovf_d = 1'b0;
                end
            end
            if (COARSEENABLE) begin
                if (COARSEINC ? (coarse_q == 3'd7) : (coarse_q == 3'd0)) begin
                    covf_d = 1'b1;
                end else begin
                    coarse_d = COARSEINC ? coarse_q + 3'd1 : coarse_q - 3'd1;
                    covf_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            fine_q   <= FINE_RV;
            coarse_q <= CRS_RV;
            fovf_q   <= 1'b0;
            covf_q   <= 1'b0;
            rdval_q  <= 9'd0;
        end else begin
            fine_q   <= fine_d;
            coarse_q <= coarse_d;
            fovf_q   <= fovf_d;
            covf_q   <= covf_d;
            // Capture uses pre-edge taps, so a same-cycle load reads the old value.
            if (COUNTERREADEN) rdval_q <= {coarse_q, fine_q};
        end
    end

    // --------------------------------------------------------------- divider
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] cnt_inc, cnt_wrap;
    logic       oclk_q, oclk_d;

    // cnt < CLKOUT_DIV and step <= 2 <= CLKOUT_DIV, so one conditional subtract wraps.
    always_comb begin
        cnt_inc  = {1'b0, cnt_q} + (EDGEADV ? 5'd2 : 5'd1);
        cnt_wrap = (cnt_inc >= DIV_W) ? cnt_inc - DIV_W : cnt_inc;
        cnt_d    = DIVIDERST ? PARK : cnt_wrap[3:0];
        // Decoded from the next count so OCLKDIV lines up with cnt.
        oclk_d   = !DIVIDERST && ({1'b0, cnt_d} < HALF_W);
    end

    always_ff @(posedge SYSCLK or negedge RSTB) begin
        if (!RSTB) begin
            cnt_q  <= PARK;
            oclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            oclk_q <= oclk_d;
        end
    end

    // ------------------------------------------------------ OSERDES reset
    logic osr_q;

    if (EN_OSERDES_RST == "TRUE") begin : g_osr
        logic zhit_q;   // first cnt==0 after release already seen

        always_ff @(posedge SYSCLK or negedge RSTB) begin
            if (!RSTB) begin
                osr_q  <= 1'b1;
                zhit_q <= 1'b0;
            end else if (DIVIDERST) begin
                osr_q  <= 1'b1;
                zhit_q <= 1'b0;
            end else if (osr_q && cnt_d == 4'd0) begin
                if (zhit_q) osr_q  <= 1'b0;
                else        zhit_q <= 1'b1;
            end
        end
    end else begin : g_no_osr
        assign osr_q = 1'b0;
    end

    assign COUNTERREADVAL = rdval_q;
    assign FINEOVERFLOW   = fovf_q;
    assign COARSEOVERFLOW = covf_q;
    assign OCLKDIV        = oclk_q;
    assign OSERDESRST     = osr_q;

endmodule

// File: tb/tb_x_phaser_out_ctl.sv
// Directed bench for x_phaser_out_ctl. Main DUT: div 4, FINE 5, COARSE 2,
// OSERDESRST enabled. Second DUT: div 3, sequencer disabled, same inputs.
module tb_x_phaser_out_ctl;

    logic       SYSCLK = 1'b0;
    logic       RSTB;
    logic       FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
    logic       COUNTERLOADEN, COUNTERREADEN, DIVIDERST, EDGEADV;
    logic [8:0] COUNTERLOADVAL;
    logic [8:0] rdval, rdval3;
    logic       fovf, covf, oclk, osr;
    logic       fovf3, covf3, oclk3, osr3;

    int checks = 0;
    int errors = 0;

    always #5 SYSCLK = ~SYSCLK;

    x_phaser_out_ctl #(
        .CLKOUT_DIV(4), .FINE_DELAY(5), .COARSE_DELAY(2), .EN_OSERDES_RST("TRUE")
    ) u_dut (
        .SYSCLK(SYSCLK), .RSTB(RSTB),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
        .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
        .COUNTERREADEN(COUNTERREADEN), .DIVIDERST(DIVIDERST), .EDGEADV(EDGEADV),
        .COUNTERREADVAL(rdval), .FINEOVERFLOW(fovf), .COARSEOVERFLOW(covf),
        .OCLKDIV(oclk), .OSERDESRST(osr)
    );

    x_phaser_out_ctl #(
        .CLKOUT_DIV(3), .FINE_DELAY(0), .COARSE_DELAY(0), .EN_OSERDES_RST("FALSE")
    ) u_dut3 (
        .SYSCLK(SYSCLK), .RSTB(RSTB),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
        .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
        .COUNTERREADEN(COUNTERREADEN), .DIVIDERST(DIVIDERST), .EDGEADV(EDGEADV),
        .COUNTERREADVAL(rdval3), .FINEOVERFLOW(fovf3), .COARSEOVERFLOW(covf3),
        .OCLKDIV(oclk3), .OSERDESRST(osr3)
    );

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic clear_strobes();
        FINEENABLE = 0; COARSEENABLE = 0; COUNTERLOADEN = 0;
        COUNTERREADEN = 0; EDGEADV = 0;
    endtask

    task automatic do_read();
        COUNTERREADEN = 1;
        tick();
        COUNTERREADEN = 0;
    endtask

    task automatic do_load(input logic [8:0] v);
        COUNTERLOADVAL = v;
        COUNTERLOADEN  = 1;
        tick();
        COUNTERLOADEN  = 0;
    endtask

    task automatic test_reset();
        RSTB = 0; DIVIDERST = 1; FINEINC = 0; COARSEINC = 0;
        COUNTERLOADVAL = 9'd0;
        clear_strobes();
        #23;
        checks++;
        if (rdval !== 9'd0 || fovf !== 1'b0 || covf !== 1'b0) begin
            errors++;
            $display("FAIL reset_taps rdval=%h fovf=%b covf=%b required 000 0 0", rdval, fovf, covf);
        end
        checks++;
        if (oclk !== 1'b0 || osr !== 1'b1 || osr3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_div oclk=%b osr=%b osr3=%b required 0 1 0", oclk, osr, osr3);
        end
        @(negedge SYSCLK);
        RSTB = 1;
        do_read();
        checks++;
        if (rdval !== 9'h085) begin
            errors++;
            $display("FAIL reset_readback got %h required 085", rdval);
        end
    endtask

    task automatic test_saturate();
        do_load(9'h1FF);
        FINEENABLE = 1; FINEINC = 1;
        tick();
        checks++;
        if (fovf !== 1'b1) begin
            errors++;
            $display("FAIL fine_ovf_first got %b required 1", fovf);
        end
        tick();
        FINEENABLE = 0;
        do_read();
        checks++;
        if (rdval !== 9'h1FF || fovf !== 1'b1) begin
            errors++;
            $display("FAIL fine_hold63 rdval=%h fovf=%b required 1ff 1", rdval, fovf);
        end
        FINEENABLE = 1; FINEINC = 0;
        tick();
        FINEENABLE = 0;
        checks++;
        if (fovf !== 1'b0) begin
            errors++;
            $display("FAIL fine_ovf_clear got %b required 0", fovf);
        end
        // coarse at 7 stepping up -> overflow, fine untouched
        COARSEENABLE = 1; COARSEINC = 1;
        tick();
        COARSEENABLE = 0;
        checks++;
        if (covf !== 1'b1 || fovf !== 1'b0) begin
            errors++;
            $display("FAIL coarse_ovf_top covf=%b fovf=%b required 1 0", covf, fovf);
        end
        // simultaneous coarse and fine decrement both take effect
        COARSEENABLE = 1; COARSEINC = 0; FINEENABLE = 1; FINEINC = 0;
        tick();
        clear_strobes();
        do_read();
        checks++;
        if (rdval !== 9'h1BD || covf !== 1'b0) begin
            errors++;
            $display("FAIL dual_step rdval=%h covf=%b required 1bd 0", rdval, covf);
        end
        do_load(9'h000);
        COARSEENABLE = 1; COARSEINC = 0;
        tick();
        COARSEENABLE = 0;
        checks++;
        if (covf !== 1'b1) begin
            errors++;
            $display("FAIL coarse_ovf_bottom got %b required 1", covf);
        end
    endtask

    task automatic test_load_priority();
        COUNTERLOADVAL = 9'h010; COUNTERLOADEN = 1;
        FINEENABLE = 1; FINEINC = 1; COUNTERREADEN = 1;
        tick();
        clear_strobes();
        checks++;
        if (rdval !== 9'h000 || covf !== 1'b0) begin
            errors++;
            $display("FAIL load_read_old rdval=%h covf=%b required 000 0", rdval, covf);
        end
        do_read();
        checks++;
        if (rdval !== 9'h010) begin
            errors++;
            $display("FAIL load_override got %h required 010", rdval);
        end
    endtask

    task automatic test_divider();
        logic [8:0] e4, e3;
        e4 = 9'b0_0110_0110 >> 0;   // edges N..N+8 for div 4: 1,1,0,0,1,1,0,0,1
        e4 = 9'b100110011;          // bit k = expected OCLKDIV after edge N+k
        e3 = 9'b001001001;          // div 3: 1,0,0,1,0,0,1,0,0
        checks++;
        if (oclk !== 1'b0 || oclk3 !== 1'b0 || osr !== 1'b1) begin
            errors++;
            $display("FAIL div_held oclk=%b oclk3=%b osr=%b required 0 0 1", oclk, oclk3, osr);
        end
        DIVIDERST = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (oclk !== e4[k] || oclk3 !== e3[k]) begin
                errors++;
                $display("FAIL div_seq k=%0d oclk=%b oclk3=%b required %b %b", k, oclk, oclk3, e4[k], e3[k]);
            end
            checks++;
            if (osr !== (k < 4) || osr3 !== 1'b0) begin
                errors++;
                $display("FAIL oserdesrst k=%0d osr=%b osr3=%b required %b 0", k, osr, osr3, (k < 4));
            end
        end
    endtask

    task automatic test_edgeadv();
        logic [4:0] f4, f3;
        f4 = 5'b10011;   // div 4 after the advance: cnt 0,1,2,3,0
        f3 = 5'b01001;   // div 3 after the advance: cnt 0,1,2,0,1
        tick();          // div 4 cnt = 1, div 3 cnt = 0
        EDGEADV = 1;
        tick();          // div 4 cnt 1->3, div 3 cnt 0->2
        EDGEADV = 0;
        checks++;
        if (oclk !== 1'b0 || oclk3 !== 1'b0) begin
            errors++;
            $display("FAIL edgeadv_jump oclk=%b oclk3=%b required 0 0", oclk, oclk3);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (oclk !== f4[k] || oclk3 !== f3[k]) begin
                errors++;
                $display("FAIL edgeadv_seq k=%0d oclk=%b oclk3=%b required %b %b", k, oclk, oclk3, f4[k], f3[k]);
            end
        end
        // DIVIDERST wins over a same-cycle EDGEADV
        DIVIDERST = 1; EDGEADV = 1;
        tick();
        EDGEADV = 0;
        checks++;
        if (oclk !== 1'b0 || osr !== 1'b1) begin
            errors++;
            $display("FAIL divrst_beats_adv oclk=%b osr=%b required 0 1", oclk, osr);
        end
        DIVIDERST = 0;
        tick();
        checks++;
        if (oclk !== 1'b1 || oclk3 !== 1'b1) begin
            errors++;
            $display("FAIL divrst_release oclk=%b oclk3=%b required 1 1", oclk, oclk3);
        end
    endtask

    task automatic test_async_reset();
        do_load(9'h0E8);   // coarse 3, fine 40
        do_read();
        tick(); tick();    // divider 4 edges past release: cnt = 0
        checks++;
        if (rdval !== 9'h0E8 || oclk !== 1'b1 || osr !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset rdval=%h oclk=%b osr=%b required 0e8 1 0", rdval, oclk, osr);
        end
        #2;
        RSTB = 0;
        #1;
        checks++;
        if (oclk !== 1'b0 || osr !== 1'b1 || rdval !== 9'd0) begin
            errors++;
            $display("FAIL async_reset oclk=%b osr=%b rdval=%h required 0 1 000", oclk, osr, rdval);
        end
        @(negedge SYSCLK);
        RSTB = 1;
        do_read();         // first edge after release restarts the divider
        checks++;
        if (rdval !== 9'h085 || oclk !== 1'b1 || osr !== 1'b1) begin
            errors++;
            $display("FAIL post_reset rdval=%h oclk=%b osr=%b required 085 1 1", rdval, oclk, osr);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (osr !== 1'b0 || oclk !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_osr osr=%b oclk=%b required 0 1", osr, oclk);
        end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_load_priority();
        test_divider();
        test_edgeadv();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
